multi_ctrl: RTL and testbench
=============================

Name: multi_ctrl

Overview:
- Control FSM for the 4-bit shift-add sequential multiplier datapath `multi`.
- Issues `multi`'s control strobes: `dclr`, `ld`, `ldp`, `shp`, `shb`. It is the issuing end of the interface that `multi` receives.
- Accepts a start request, sequences one add/shift-P/shift-B round per multiplier bit, then signals completion.
- Replaces hand-driven strobe sequences; sits between the top-level handshake and `multi`.

Parameters:
- N, 4, multiplier width in bits = number of add/shift rounds. Legal range 1..16.
- CW, $clog2(N+1), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-high reset of this controller.
- start  input  1  level request. Sampled only in IDLE.
- b0  input  1  LSB of the datapath B (multiplier) register.
- ack  input  1  done acknowledge. Used only when DONE_ACK_EN is defined; ignored otherwise.
- dclr  output  1  datapath clear, drives `multi`.clr.
- ld  output  1  load A/B operands.
- ldp  output  1  load product (P upper += A).
- shp  output  1  shift P right.
- shb  output  1  shift B right.
- busy  output  1  high from CLEAR through the end of the operation.
- done  output  1  operation complete.

Behaviour:
- Reset: `clr`=1 forces, asynchronously, state=IDLE, cnt=0 and every output to 0. Applies mid-operation too: the sequence aborts and the datapath is left as is. No output glitches on reset release.
- States: IDLE, CLEAR, LOAD, ADD, SHP, SHB, DONE. Binary encoded; state register updates on the clk rising edge.
- Outputs are Moore-decoded from the state register, except `ldp`:
  - CLEAR: dclr=1.
  - LOAD: ld=1.
  - ADD: ldp = b0.
  - SHP: shp=1.
  - SHB: shb=1.
  - DONE: done=1.
  - busy=1 in every state except IDLE.
  - At most one strobe is high in any cycle.
- Transitions:
  - IDLE -> CLEAR when start=1.
  - CLEAR -> LOAD, and cnt <= N.
  - LOAD -> ADD.
  - ADD -> SHP.
  - SHP -> SHB.
  - SHB: cnt <= cnt-1. Go to ADD if cnt != 1, else DONE.
  - DONE -> IDLE (see Optional Feature).
- ADD is entered every round; `ldp` is gated by `b0` in that cycle. `b0` is stable there because B last changed at the SHB or LOAD edge.
- Latency: start sampled at edge k -> CLEAR during cycle k+1, LOAD k+2, first ADD k+3. DONE during cycle k+3+3N.
  - N=4: 15 cycles from the start edge to done.
- `start` while busy: ignored, no queueing.
- `start` held high through DONE: a new operation begins (CLEAR) on the cycle after returning to IDLE.
- N=1: exactly one ADD/SHP/SHB round, then DONE.
- cnt never wraps: only loaded in CLEAR, only decremented in SHB, and SHB exits at cnt=1.

Optional Feature:
- Macro DONE_ACK_EN.
- Undefined: DONE lasts exactly one cycle (done is a 1-cycle pulse). `ack` has no effect.
- Defined: the FSM remains in DONE with done=1, busy=1 until ack=1 is sampled, then goes to IDLE.
  - ack=1 already high on DONE entry exits after one cycle, same timing as undefined.
  - `start` is ignored while in DONE.

Test Plan:
- Reset: clr=1 at time 0 and during ADD of a running operation -> all outputs 0 immediately (asynchronous). After release: IDLE, busy=0.
- Full multiply with a `multi` datapath model, A=4'b1011, B=4'b1101:
  - strobe order dclr, ld, then (ldp,shp,shb) x4.
  - ldp pulses per round 1,0,1,1.
  - done asserted 15 cycles after the start edge; product p=8'h8F (143).
- B=4'b0000, A=4'b1111 -> ldp never asserted, 4 rounds still executed, p=0, done at the same 15-cycle latency.
- start held high continuously -> back-to-back operations: done pulse, one IDLE cycle, then dclr. No two strobes ever coincide.
- start pulsed during SHP of round 2 -> ignored: one done only, timing unchanged.
- DONE_ACK_EN defined: ack held 0 for 5 cycles -> done stays 1 for 5 cycles. ack=1 -> IDLE next cycle, done=0, busy=0.

Source files
------------

// File: rtl/multi_ctrl.sv
// multi_ctrl: control FSM for the 4-bit shift-add multiplier `multi`.
// Optional macro DONE_ACK_EN: hold DONE until ack is sampled high.
//
// Ports:
//   clk   - system clock, rising edge
//   clr   - asynchronous active-high reset
//   start - level request, sampled only in IDLE
//   b0    - LSB of datapath B register
//   ack   - done acknowledge (DONE_ACK_EN builds only)
//   dclr  - datapath clear strobe
//   ld    - load A/B operands
//   ldp   - P upper += A (gated by b0)
//   shp   - shift P right
//   shb   - shift B right
//   busy  - operation in progress (any state but IDLE)
//   done  - operation complete
module multi_ctrl #(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic b0,
    input  logic ack,
    output logic dclr,
    output logic ld,
    output logic ldp,
    output logic shp,
    output logic shb,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_ADD,
        S_SHP,
        S_SHB,
        S_DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

`ifndef DONE_ACK_EN
    logic unused_ack;
    assign unused_ack = ack;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        dclr    = 1'b0;
        ld      = 1'b0;
        ldp     = 1'b0;
        shp     = 1'b0;
        shb     = 1'b0;
        done    = 1'b0;
        busy    = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (start) nxt = S_CLEAR;
            end
            S_CLEAR: begin
                dclr    = 1'b1;
                cnt_nxt = CW'(N);
                nxt     = S_LOAD;
            end
            S_LOAD: begin
                ld  = 1'b1;
                nxt = S_ADD;
            end
            S_ADD: begin
                // B is stable here: it last moved at LOAD/SHB
                ldp = b0;
                nxt = S_SHP;
            end
            S_SHP: begin
                shp = 1'b1;
                nxt = S_SHB;
            end
            S_SHB: begin
                shb     = 1'b1;
                cnt_nxt = cnt - 1'b1;
                // exit at 1 so cnt never wraps
                if (cnt != CW'(1)) nxt = S_ADD;
                else               nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
`ifdef DONE_ACK_EN
                if (ack) nxt = S_IDLE;
`else
                nxt = S_IDLE;
`endif
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_ctrl.sv
// tb_multi_ctrl: directed self-checking bench for multi_ctrl,
// with a behavioural model of the `multi` datapath.
module tb_multi_ctrl;

    logic clk = 1'b0;
    logic clr;
    logic start;
    logic b0;
    logic ack;
    logic dclr, ld, ldp, shp, shb, busy, done;

    int tests = 0;
    int fails = 0;
    int ndone = 0;

    // datapath model
    logic [3:0] opa, opb;
    logic [3:0] ra, rb;
    logic [8:0] p;

    logic [6:0] vec;
    assign vec = {dclr, ld, ldp, shp, shb, done, busy};
    assign b0  = rb[0];

    multi_ctrl #(.N(4)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .b0    (b0),
        .ack   (ack),
        .dclr  (dclr),
        .ld    (ld),
        .ldp   (ldp),
        .shp   (shp),
        .shb   (shb),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        ra = '0;
        rb = '0;
        p  = '0;
    end

    always @(posedge clk) begin
        if (dclr) p <= '0;
        if (ld) begin
            ra <= opa;
            rb <= opb;
        end
        if (ldp) p[8:4] <= {1'b0, p[7:4]} + {1'b0, ra};
        if (shp) p <= p >> 1;
        if (shb) rb <= rb >> 1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // at most one strobe per cycle
    always @(negedge clk) begin
        if (!clr)
            chk("onehot",
                32'($countones({dclr, ld, ldp, shp, shb}) <= 1),
                32'd1);
        if (done) ndone++;
    end

    // expected {dclr,ld,ldp,shp,shb,done,busy} in cycle i
    // after the start edge
    function automatic logic [6:0] expv(input int i,
                                        input logic [3:0] b);
        logic [6:0] v;
        int r, ph;
        v = 7'b0000001;
        if (i == 1) v[6] = 1'b1;
        else if (i == 2) v[5] = 1'b1;
        else if (i == 15) v[1] = 1'b1;
        else begin
            r  = (i - 3) / 3;
            ph = (i - 3) % 3;
            if (ph == 0) v[4] = b[r];
            else if (ph == 1) v[3] = 1'b1;
            else v[2] = 1'b1;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // check cycles from..15; optional start pulse in SHP of round 2
    task automatic run_cycles(input int from,
                              input logic [3:0] b,
                              input bit pulse,
                              input string tag);
        for (int i = from; i <= 15; i++) begin
            chk(tag, 32'(vec), 32'(expv(i, b)));
            if (pulse) start = (i == 7);
            if (i < 15) tick();
        end
    endtask

    task automatic run_op(input logic [3:0] a,
                          input logic [3:0] b,
                          input bit pulse,
                          input string tag);
        int d0;
        opa   = a;
        opb   = b;
        d0    = ndone;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_cycles(1, b, pulse, tag);
        chk({tag, "_p"}, 32'(p[7:0]), 32'(8'(a * b)));
        tick();
        chk({tag, "_idle"}, 32'(vec), 32'd0);
        tick();
        tick();
        chk({tag, "_ndone"}, 32'(ndone - d0), 32'd1);
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
`ifdef DONE_ACK_EN
        ack = 1'b1;
`else
        ack = 1'b0;
`endif
        opa = '0;
        opb = '0;
        #2;
        chk("rst0_out", 32'(vec), 32'd0);
        tick();
        clr = 1'b0;
        tick();
        chk("rst0_busy", 32'(busy), 32'd0);
        chk("rst0_out2", 32'(vec), 32'd0);

        // A=1011 B=1101: ldp rounds 1,0,1,1
        run_op(4'b1011, 4'b1101, 1'b0, "mul_a");
        chk("mul_a_8f", 32'(p[7:0]), 32'h8F);

        // B=0: no ldp, same latency
        run_op(4'b1111, 4'b0000, 1'b0, "mul_b0");
        chk("mul_b0_p", 32'(p[7:0]), 32'h00);

        // start pulse during SHP of round 2 is ignored
        run_op(4'b1011, 4'b1101, 1'b1, "mul_pulse");

        run_op(4'b1111, 4'b1111, 1'b0, "mul_ff");
        chk("mul_ff_e1", 32'(p[7:0]), 32'hE1);

        // start held high: done, one IDLE, then CLEAR
        opa   = 4'b0111;
        opb   = 4'b1001;
        start = 1'b1;
        tick();
        run_cycles(1, opb, 1'b0, "b2b_1");
        tick();
        chk("b2b_idle", 32'(vec), 32'd0);
        tick();
        chk("b2b_clear", 32'(vec), 32'b1000001);
        start = 1'b0;
        tick();
        run_cycles(2, opb, 1'b0, "b2b_2");
        chk("b2b_p", 32'(p[7:0]), 32'd63);
        tick();
        chk("b2b_end", 32'(vec), 32'd0);

        // asynchronous reset during ADD
        opa   = 4'b1011;
        opb   = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_add", 32'(vec), 32'(expv(3, opb)));
        #2;
        clr = 1'b1;
        #1;
        chk("rst_mid_out", 32'(vec), 32'd0);
        tick();
        chk("rst_mid_hold", 32'(vec), 32'd0);
        #2;
        clr = 1'b0;
        tick();
        chk("rst_rel_idle", 32'(vec), 32'd0);
        tick();
        chk("rst_rel_busy", 32'(busy), 32'd0);

        run_op(4'b1011, 4'b1101, 1'b0, "mul_post");

`ifdef DONE_ACK_EN
        // DONE held until ack; start ignored there
        ack   = 1'b0;
        opa   = 4'b0011;
        opb   = 4'b0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_cycles(1, opb, 1'b0, "ack_op");
        for (int j = 1; j <= 4; j++) begin
            start = (j == 1 || j == 2);
            tick();
            chk("ack_hold", 32'(vec), 32'b0000011);
        end
        start = 1'b0;
        ack   = 1'b1;
        tick();
        chk("ack_idle", 32'(vec), 32'd0);
        chk("ack_p", 32'(p[7:0]), 32'd15);
`else
        // ack high has no effect: still one-cycle done
        ack = 1'b1;
        run_op(4'b0011, 4'b0101, 1'b0, "noack");
        ack = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
